// File: rtl/mod5_pkg.sv
// Shared types and constants for the mod-5 sequence monitor.
// The state enum, the wrap point of the upstream counter and the good-wrap counter width live here.
package mod5_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [2:0] MOD5_FIRST = 3'd0;
  localparam logic [2:0] MOD5_LAST  = 3'd4;

  // Wide enough for the largest allowed LOCK_WRAPS (15).
  localparam int GW_W = 4;

endpackage

// File: rtl/mod5_succ.sv
// Combinational successor of a mod-5 count value.
// Also flags encodings 5..7, which a mod-5 counter never produces.
module mod5_succ
  import mod5_pkg::*;
(
  input  logic [2:0] cur,
  output logic [2:0] succ,
  output logic       illegal
);

  always_comb begin
    illegal = (cur > MOD5_LAST);
    if (cur == MOD5_LAST) succ = MOD5_FIRST;
    else                  succ = cur + 3'd1;
  end

endmodule

// File: rtl/mod5_monitor.sv
// Monitors a mod-5 counter stream: locks after LOCK_WRAPS clean wraps,
// then pulses once per wrap and records sequence breaks and illegal values.
module mod5_monitor
  import mod5_pkg::*;
#(
  parameter int LOCK_WRAPS = 2,
  parameter int CYC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       count_in,
  input  logic             in_valid,
  input  logic             clear,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             err_illegal,
  output logic             err_skip,
  output logic [CYC_W-1:0] err_cnt
);

  localparam logic [CYC_W-1:0] CNT_MAX     = '1;
  localparam logic [GW_W-1:0]  LOCK_TARGET = GW_W'(LOCK_WRAPS);

  state_e             state_q, state_d;
  logic [2:0]         prev_q, prev_d;
  logic [GW_W-1:0]    good_wraps_q, good_wraps_d;
  logic               locked_q, locked_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_skip_q, err_skip_d;
  logic [CYC_W-1:0]   err_cnt_q, err_cnt_d;

  logic [2:0] expected;
  logic       prev_illegal;
  logic       sample_illegal;
  logic       seq_ok;
  logic       is_wrap;
  logic       err_event;
  logic       skip_event;
  logic       wrap_event;

  mod5_succ u_succ (
    .cur     (prev_q),
    .succ    (expected),
    .illegal (prev_illegal)
  );

  // An illegal prev (left over from a 5..7 sample) can never be followed in sequence.
  assign sample_illegal = (count_in > MOD5_LAST);
  assign seq_ok         = !prev_illegal && (count_in == expected);
  assign is_wrap        = seq_ok && (prev_q == MOD5_LAST);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    prev_d        = prev_q;
    good_wraps_d  = good_wraps_q;
    cycle_cnt_d   = cycle_cnt_q;
    err_illegal_d = err_illegal_q;
    err_skip_d    = err_skip_q;
    err_cnt_d     = err_cnt_q;
    err_event     = 1'b0;
    skip_event    = 1'b0;
    wrap_event    = 1'b0;

    if (in_valid) begin
      prev_d = count_in;
      if (sample_illegal) begin
        state_d   = ST_UNLOCKED;
        err_event = 1'b1;
      end else begin
        unique case (state_q)
          ST_UNLOCKED: begin
            if (count_in == MOD5_FIRST) begin
              state_d      = ST_SYNCING;
              good_wraps_d = '0;
            end
          end
          ST_SYNCING: begin
            if (!seq_ok) begin
              state_d = ST_UNLOCKED;
            end else if (is_wrap) begin
              good_wraps_d = good_wraps_q + GW_W'(1);
              if (good_wraps_q + GW_W'(1) == LOCK_TARGET) state_d = ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (!seq_ok) begin
              state_d    = ST_UNLOCKED;
              skip_event = 1'b1;
              err_event  = 1'b1;
            end else if (is_wrap) begin
              wrap_event = 1'b1;
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end

    // Clear is applied first so a coincident event lands on top of the zeroed statistics.
    if (clear) begin
      cycle_cnt_d   = '0;
      err_cnt_d     = '0;
      err_illegal_d = 1'b0;
      err_skip_d    = 1'b0;
    end
    if (wrap_event)                           cycle_cnt_d   = cycle_cnt_d + CYC_W'(1);
    if (err_event && (err_cnt_d != CNT_MAX))  err_cnt_d     = err_cnt_d + CYC_W'(1);
    if (in_valid && sample_illegal)           err_illegal_d = 1'b1;
    if (skip_event)                           err_skip_d    = 1'b1;

    wrap_pulse_d = wrap_event;
    locked_d     = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_UNLOCKED;
      prev_q        <= MOD5_FIRST;
      good_wraps_q  <= '0;
      locked_q      <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      cycle_cnt_q   <= '0;
      err_illegal_q <= 1'b0;
      err_skip_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q       <= state_d;
      prev_q        <= prev_d;
      good_wraps_q  <= good_wraps_d;
      locked_q      <= locked_d;
      wrap_pulse_q  <= wrap_pulse_d;
      cycle_cnt_q   <= cycle_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_skip_q    <= err_skip_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign err_illegal = err_illegal_q;
  assign err_skip    = err_skip_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mod5_monitor.sv
// Scoreboard bench for mod5_monitor: directed scenarios followed by randomized stream traffic.
// The reference model tracks the length of the current in-order run rather than an FSM.
module tb_mod5_monitor;

  localparam int LW = 2;
  localparam int CW = 2;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    count_in;
  logic          in_valid;
  logic          clear;
  logic          locked;
  logic          wrap_pulse;
  logic [CW-1:0] cycle_cnt;
  logic          err_illegal;
  logic          err_skip;
  logic [CW-1:0] err_cnt;

  mod5_monitor #(.LOCK_WRAPS(LW), .CYC_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .in_valid    (in_valid),
    .clear       (clear),
    .locked      (locked),
    .wrap_pulse  (wrap_pulse),
    .cycle_cnt   (cycle_cnt),
    .err_illegal (err_illegal),
    .err_skip    (err_skip),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int wrap_pulse;
    int cyc;
    int ill;
    int skip;
    int errc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // run = number of samples in the current in-order chain that began at a 0 (0 = not syncing)
  int run    = 0;
  int m_cyc  = 0;
  int m_errc = 0;
  int m_ill  = 0;
  int m_skip = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_locked();
    return (run > 0 && (run - 1) / 5 >= LW) ? 1 : 0;
  endfunction

  task automatic model_reset();
    run = 0; m_cyc = 0; m_errc = 0; m_ill = 0; m_skip = 0;
  endtask

  task automatic model_step(input bit v, input int x, input bit clr);
    exp_t e;
    int   pulse = 0;
    int   err   = 0;
    if (clr) begin
      m_cyc = 0; m_errc = 0; m_ill = 0; m_skip = 0;
    end
    if (v) begin
      if (x > 4) begin
        m_ill = 1; err = 1; run = 0;
      end else if (run == 0) begin
        if (x == 0) run = 1;
      end else if (x == run % 5) begin
        if (x == 0 && model_locked() == 1) pulse = 1;
        run++;
      end else begin
        if (model_locked() == 1) begin
          m_skip = 1; err = 1;
        end
        run = 0;
      end
    end
    if (err == 1 && m_errc < CNT_MOD - 1) m_errc++;
    if (pulse == 1) m_cyc = (m_cyc + 1) % CNT_MOD;
    e.locked = model_locked(); e.wrap_pulse = pulse; e.cyc = m_cyc;
    e.ill = m_ill; e.skip = m_skip; e.errc = m_errc;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input logic [2:0] x, input bit clr = 1'b0);
    in_valid = v; count_in = x; clear = clr;
    @(posedge clk);
    model_step(v, int'(x), clr);
    #1;
  endtask

  task automatic stream(input int start, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 3'((start + i) % 5));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)));
  endtask

  // Asserts rst mid-cycle and checks outputs clear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
    #1;
    check("rst_locked",      int'(locked),      0);
    check("rst_wrap_pulse",  int'(wrap_pulse),  0);
    check("rst_cycle_cnt",   int'(cycle_cnt),   0);
    check("rst_err_illegal", int'(err_illegal), 0);
    check("rst_err_skip",    int'(err_skip),    0);
    check("rst_err_cnt",     int'(err_cnt),     0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("locked",      int'(locked),      e.locked);
      check("wrap_pulse",  int'(wrap_pulse),  e.wrap_pulse);
      check("cycle_cnt",   int'(cycle_cnt),   e.cyc);
      check("err_illegal", int'(err_illegal), e.ill);
      check("err_skip",    int'(err_skip),    e.skip);
      check("err_cnt",     int'(err_cnt),     e.errc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int src;
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; count_in = 3'd0;
    do_reset();

    // Clean lock: five wraps, lock after the second, pulses from the third.
    stream(0, 26);
    // Skip while locked, then restart syncing on the next 0.
    step(1'b1, 3'd1); step(1'b1, 3'd3);
    stream(0, 7);
    // Illegal value while syncing.
    step(1'b1, 3'd6);

    // Gaps in a locked stream between 2 and 3.
    do_reset();
    stream(0, 13);
    gap(3);
    stream(3, 8);
    // Clear coinciding with a skip error.
    step(1'b1, 3'd1);
    step(1'b1, 3'd3, 1'b1);
    // Relock, then clear alone while locked, then clear coinciding with a wrap pulse.
    stream(0, 11);
    step(1'b0, 3'd0, 1'b1);
    stream(1, 4);
    step(1'b1, 3'd0, 1'b1);
    stream(1, 4);
    // Saturation: five errors on a two-bit counter.
    for (int i = 0; i < 5; i++) step(1'b1, 3'(5 + i % 3));
    stream(0, 3);
    step(1'b1, 3'd0);
    do_reset();

    // Randomized stream with occasional faults, gaps, clears and resets.
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      bit       v;
      bit       c;
      logic [2:0] x;
      v = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 2);
      x = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(0, 7)) : 3'(src);
      step(v, x, c);
      if (v) src = (src + 1) % 5;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        src = $urandom_range(0, 4);
      end
    end

    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    @(negedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
